// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO bus arbiter and its helpers.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_e;

  localparam int unsigned M_CPU = 0;
  localparam int unsigned M_DBG = 1;

  // Register map seen through the GPIO address decoder
  localparam logic [1:0] GPIO_STATUS = 2'b00;
  localparam logic [1:0] GPIO_INPUT  = 2'b01;
  localparam logic [1:0] GPIO_OUT1   = 2'b10;
  localparam logic [1:0] GPIO_OUT2   = 2'b11;

endpackage

// File: rtl/gpio_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the
// master that did not own the bus last.
module gpio_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win    = 2'b00;
    win[0] = req[0] & (~req[1] | last);
    win[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/gpio_bus_arb.sv
// Two-master arbiter and access sequencer in front of the GPIO register block:
// grants one master, holds the decoder address for the read latency, returns an ack.
module gpio_bus_arb
  import gpio_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 2,
  parameter int unsigned RD_LAT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    m_req,
  input  logic [1:0]    m_we,
  input  logic [AW-1:0] m0_a,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m0_wd,
  input  logic [DW-1:0] m1_wd,
  output logic [1:0]    m_gnt,
  output logic [1:0]    m_ack,
  output logic [DW-1:0] m_rd,
  output logic [AW-1:0] periph_a,
  output logic          periph_we,
  output logic [DW-1:0] periph_wd,
  input  logic [DW-1:0] periph_rd
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LatLoad = CW'(RD_LAT);
  localparam logic HasLat = (RD_LAT != 0);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_last;
  logic [1:0]    r_gnt;
  logic [AW-1:0] r_a;
  logic          r_we;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_win;
  logic          w_start;
  logic          w_capture;

  gpio_rr_pick u_pick (
    .req  (m_req),
    .last (r_last),
    .win  (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|m_req) begin
          w_start     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!r_we && HasLat) begin
          w_state_nxt = WAIT;
        end else begin
          w_capture   = ~r_we;
          w_state_nxt = DONE;
        end
      end
      WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ack     = 2'b00;
    periph_a  = '0;
    periph_we = 1'b0;
    periph_wd = '0;
    unique case (r_state)
      ACCESS: begin
        periph_a  = r_a;
        periph_we = r_we;
        periph_wd = r_wd;
      end
      WAIT:    periph_a = r_a;
      DONE:    m_ack = r_gnt;
      default: ;
    endcase
  end

  // Owner's request is latched so later changes on the master side are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_gnt  <= 2'b00;
      r_a    <= '0;
      r_we   <= 1'b0;
      r_wd   <= '0;
      r_cnt  <= '0;
      r_rd   <= '0;
    end else begin
      if (w_start) begin
        r_gnt  <= w_win;
        r_last <= w_win[1];
        r_a    <= w_win[1] ? m1_a : m0_a;
        r_we   <= w_win[1] ? m_we[1] : m_we[0];
        r_wd   <= w_win[1] ? m1_wd : m0_wd;
      end else if (r_state == DONE) begin
        r_gnt <= 2'b00;
      end
      if (r_state == ACCESS && !r_we && HasLat) begin
        r_cnt <= LatLoad;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_capture) begin
        r_rd <= periph_rd;
      end
    end
  end

  assign m_gnt = r_gnt;
  assign m_rd  = r_rd;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Randomized scoreboard bench for gpio_bus_arb: a transaction-level model predicts
// grant order and read data; a monitor checks every grant, access and ack.
module tb_gpio_bus_arb;

  localparam int unsigned RD_LAT = 2;

  typedef struct {
    int          owner;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        early;
    logic [31:0] rd;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [1:0]  m0_a = '0;
  logic [1:0]  m1_a = '0;
  logic [31:0] m0_wd = '0;
  logic [31:0] m1_wd = '0;
  logic [1:0]  m_gnt;
  logic [1:0]  m_ack;
  logic [31:0] m_rd;
  logic [1:0]  periph_a;
  logic        periph_we;
  logic [31:0] periph_wd;
  logic [31:0] periph_rd;
  logic [31:0] regs [4];

  int n_checks = 0;
  int n_fail = 0;

  txn_t mq0[$];
  txn_t mq1[$];
  txn_t expq[$];
  txn_t s0[$];
  txn_t s1[$];
  int   mlast = 1;
  logic [31:0] mrd = '0;
  int   gcnt = 0;

  gpio_bus_arb #(
    .DW     (32),
    .AW     (2),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_we      (m_we),
    .m0_a      (m0_a),
    .m1_a      (m1_a),
    .m0_wd     (m0_wd),
    .m1_wd     (m1_wd),
    .m_gnt     (m_gnt),
    .m_ack     (m_ack),
    .m_rd      (m_rd),
    .periph_a  (periph_a),
    .periph_we (periph_we),
    .periph_wd (periph_wd),
    .periph_rd (periph_rd)
  );

  always #5 clk = ~clk;

  assign periph_rd = regs[periph_a];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [1:0] a, input logic [31:0] wd,
                              input logic early);
    txn_t t;
    t.owner = 0;
    t.we    = we;
    t.a     = a;
    t.wd    = wd;
    t.early = early;
    t.rd    = '0;
    return t;
  endfunction

  function automatic logic [1:0] onehot(input int owner);
    return (owner == 1) ? 2'b10 : 2'b01;
  endfunction

  // Master drivers: each keeps requesting while it has queued work, holding fields until ack
  always @(negedge clk) begin
    if (m_ack[0] && mq0.size() > 0) void'(mq0.pop_front());
    if (m_ack[1] && mq1.size() > 0) void'(mq1.pop_front());
    if (mq0.size() > 0) begin
      m_req[0] = !(mq0[0].early && m_gnt[0] && !m_ack[0]);
      m_we[0]  = mq0[0].we;
      m0_a     = mq0[0].a;
      m0_wd    = mq0[0].wd;
    end else begin
      m_req[0] = 1'b0;
      m_we[0]  = 1'($urandom);
      m0_a     = 2'($urandom);
      m0_wd    = $urandom;
    end
    if (mq1.size() > 0) begin
      m_req[1] = !(mq1[0].early && m_gnt[1] && !m_ack[1]);
      m_we[1]  = mq1[0].we;
      m1_a     = mq1[0].a;
      m1_wd    = mq1[0].wd;
    end else begin
      m_req[1] = 1'b0;
      m_we[1]  = 1'($urandom);
      m1_a     = 2'($urandom);
      m1_wd    = $urandom;
    end
  end

  // Monitor: compares every bus-visible event against the head of the expected queue
  always @(negedge clk) begin
    if (!rst_n) begin
      gcnt = 0;
    end else begin
      gcnt = (m_gnt == 2'b00) ? 0 : gcnt + 1;
      if (m_gnt != 2'b00) begin
        if (expq.size() == 0) chk("gnt_unexpected", 64'(m_gnt), 64'd0);
        else chk("gnt_owner", 64'(m_gnt), 64'(onehot(expq[0].owner)));
      end
      if (m_ack != 2'b00) begin
        if (expq.size() == 0) begin
          chk("ack_unexpected", 64'(m_ack), 64'd0);
        end else begin
          chk("ack_owner", 64'(m_ack), 64'(onehot(expq[0].owner)));
          chk("m_rd", 64'(m_rd), 64'(expq[0].rd));
          chk("latency", 64'(gcnt), expq[0].we ? 64'd2 : 64'(2 + RD_LAT));
          chk("done_periph_a", 64'(periph_a), 64'd0);
          chk("done_periph_wd", 64'(periph_wd), 64'd0);
          void'(expq.pop_front());
        end
        chk("done_periph_we", 64'(periph_we), 64'd0);
      end else if (m_gnt != 2'b00 && expq.size() > 0) begin
        chk("periph_a_hold", 64'(periph_a), 64'(expq[0].a));
        chk("periph_we", 64'(periph_we), 64'(expq[0].we && gcnt == 1));
        if (periph_we) chk("periph_wd", 64'(periph_wd), 64'(expq[0].wd));
      end else if (m_gnt == 2'b00) begin
        chk("idle_periph_we", 64'(periph_we), 64'd0);
      end
    end
  end

  // Reference model: serve pending masters, lone requester first, ties to the non-last owner
  task automatic issue_batch();
    int i0 = 0;
    int i1 = 0;
    int own;
    txn_t t;
    while (i0 < s0.size() || i1 < s1.size()) begin
      if (i0 < s0.size() && i1 < s1.size()) own = (mlast == 1) ? 0 : 1;
      else own = (i0 < s0.size()) ? 0 : 1;
      t = (own == 1) ? s1[i1] : s0[i0];
      if (own == 1) i1++;
      else i0++;
      t.owner = own;
      if (!t.we) mrd = regs[t.a];
      t.rd = mrd;
      expq.push_back(t);
      mlast = own;
    end
    foreach (s0[i]) mq0.push_back(s0[i]);
    foreach (s1[i]) mq1.push_back(s1[i]);
    s0.delete();
    s1.delete();
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400 && expq.size() != 0; c++) @(posedge clk);
    chk("timeout_pending", 64'(expq.size()), 64'd0);
    expq.delete();
    mq0.delete();
    mq1.delete();
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    foreach (regs[i]) regs[i] = $urandom;
    repeat (3) @(posedge clk);
    chk("reset_gnt", 64'(m_gnt), 64'd0);
    chk("reset_ack", 64'(m_ack), 64'd0);
    chk("reset_rd", 64'(m_rd), 64'd0);
    chk("reset_periph", 64'({periph_a, periph_we, periph_wd}), 64'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Single write from the CPU port
    s0.push_back(mk(1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0));
    issue_batch();
    wait_done();

    // Single read from the debug port through the latency window
    regs[1] = 32'h0000_00A5;
    s1.push_back(mk(1'b0, 2'b01, 32'h0, 1'b0));
    issue_batch();
    wait_done();
    chk("rd_a5", 64'(m_rd), 64'h0000_00A5);

    // Both continuously requesting: strict alternation
    for (int i = 0; i < 3; i++) begin
      s0.push_back(mk(1'($urandom), 2'($urandom), $urandom, 1'b0));
      s1.push_back(mk(1'($urandom), 2'($urandom), $urandom, 1'b0));
    end
    issue_batch();
    wait_done();

    // Request dropped right after grant still completes
    s0.push_back(mk(1'b0, 2'b11, 32'h0, 1'b1));
    issue_batch();
    wait_done();

    // Reset in the middle of a read's WAIT phase
    s1.push_back(mk(1'b0, 2'b01, 32'h0, 1'b0));
    issue_batch();
    for (int c = 0; c < 20 && m_gnt == 2'b00; c++) @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 64'(m_gnt), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_rd", 64'(m_rd), 64'd0);
    chk("rst_periph", 64'({periph_a, periph_we, periph_wd}), 64'd0);
    expq.delete();
    mq0.delete();
    mq1.delete();
    mlast = 1;
    mrd = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_rd", 64'(m_rd), 64'd0);
    s0.push_back(mk(1'b1, 2'b10, $urandom, 1'b0));
    s1.push_back(mk(1'b1, 2'b11, $urandom, 1'b0));
    issue_batch();
    wait_done();

    // Write then read from one master: the write must not disturb m_rd
    s0.push_back(mk(1'b1, 2'b10, 32'h0000_1234, 1'b0));
    s0.push_back(mk(1'b0, 2'b11, 32'h0, 1'b0));
    issue_batch();
    wait_done();

    for (int b = 0; b < 25; b++) begin
      foreach (regs[i]) regs[i] = $urandom;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        s0.push_back(mk(1'($urandom), 2'($urandom), $urandom, ($urandom_range(0, 3) == 0)));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        s1.push_back(mk(1'($urandom), 2'($urandom), $urandom, ($urandom_range(0, 3) == 0)));
      issue_batch();
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
